// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmit serialiser with valid/ready byte input.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_in_i,
  input  logic       data_in_valid_i,
  output logic       data_in_ready_o,
  output logic       busy_o,
  output logic       serial_out_o
);

  localparam int unsigned T = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (T < 2) ? 1 : $clog2(T);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T - 1);

  if (T < 2) begin : g_bad_baud
    $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             line_d;
  logic             bit_last;
  logic             serial_out_q;
  logic             busy_q;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bit_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    line_d  = 1'b1;

    if (state_q != IDLE) begin
      cnt_d = bit_last ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (data_in_valid_i) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = data_in_i;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data_in_i;
`endif
        end
      end
      START: begin
        if (bit_last) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line and busy are registered from the next state so they move on the same edge as the FSM.
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = par_q;
`endif
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      serial_out_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      serial_out_q <= line_d;
      busy_q       <= (state_d != IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign data_in_ready_o = (state_q == IDLE);
  assign busy_o          = busy_q;
  assign serial_out_o    = serial_out_q;

endmodule
